gray_monitor: RTL and testbench

//   Downstream consumer of the 8-bit Gray counter output. Registers each Gray

---
 rtl/gray_mon_pkg.sv | 35 +++
 rtl/gray_to_bin.sv | 18 +
 rtl/gray_monitor.sv | 164 ++++++++++++++++
 tb/tb_gray_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_mon_pkg.sv
// gray_mon_pkg
//   Shared constants for the Gray-counter monitor: default parameters, FSM
//   state encodings and the Gray-to-binary helper.
//   The FSM states are plain localparam constants so the encoding stays
//   readable in older tools and waveform viewers.
//   Optional feature macro used by gray_monitor: GRAY_MON_STICKY_EN.
package gray_mon_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int DEF_LOCK_CNT  = 4;

  // Upper bound on WIDTH supported by gray2bin.
  localparam int GRAY_MAX_W    = 32;

  // state | meaning
  // ------+--------------------------------------------------------------
  // ACQ   | waiting for the first valid sample, which becomes the reference
  // TRACK | comparing steps, counting consecutive good steps toward lock
  // LOCK  | stream is consistent; any bad step drops back to TRACK
  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_TRACK   = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Each binary bit is the XOR of the Gray bits at and above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin
//   Combinational Gray-to-binary converter (WIDTH <= 32).
//   Ports:
//     gray_i  in   WIDTH  Gray-coded value
//     bin_o   out  WIDTH  binary equivalent
module gray_to_bin
  import gray_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Zero-extending keeps the upper result bits zero, so truncation is exact.
  assign bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_monitor.sv
// gray_monitor
//   Registers Gray samples from the upstream counter, converts them to binary
//   and checks that each valid sample is 0 or +1 (mod 2^WIDTH) from the last
//   valid one. Reports lock status, step-error pulses and a saturating count.
//   Optional: GRAY_MON_STICKY_EN adds err_sticky, set by the first step error
//   and held until reset.
//   Ports:
//     clk        in   1          clock, rising edge
//     rst        in   1          asynchronous reset, active high
//     gray_in    in   WIDTH      Gray sample
//     in_valid   in   1          gray_in valid this cycle
//     bin_out    out  WIDTH      binary value of the last accepted sample
//     bin_valid  out  1          one-cycle strobe per accepted sample
//     step_err   out  1          one-cycle pulse on an illegal step
//     locked     out  1          FSM is in LOCKED
//     err_count  out  ERR_CNT_W  saturating count of step_err pulses
//     err_sticky out  1          (GRAY_MON_STICKY_EN only) any error since reset
//   Latency: sample valid in cycle N appears on the outputs in cycle N+2.
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef GRAY_MON_STICKY_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic [WIDTH-1:0]     s1_gray_q;
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_bin;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]     delta;
  logic                 step_good;
  logic                 step_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     bin_q;
  logic                 bin_valid_q;
  logic                 step_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_gray_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_gray_q  <= gray_in;
      s1_valid_q <= in_valid;
    end
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray_i (s1_gray_q),
    .bin_o  (s1_bin)
  );

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    prev_bin_d = prev_bin_q;
    step_err_d = 1'b0;
    // Unsigned subtraction wraps, so MAX -> 0 comes out as delta 1.
    delta      = s1_bin - prev_bin_q;
    step_good  = (delta <= WIDTH'(1));

    if (s1_valid_q) begin
      // Resync to every valid sample so one glitch costs one error, not many.
      prev_bin_d = s1_bin;
      case (state_q)
        ST_ACQUIRE: begin
          good_cnt_d = '0;
          state_d    = ST_TRACK;
        end
        ST_TRACK: begin
          if (step_good) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_d == CNT_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            step_err_d = 1'b1;
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!step_good) begin
            step_err_d = 1'b1;
            good_cnt_d = '0;
            state_d    = ST_TRACK;
          end
        end
        default: begin
          good_cnt_d = '0;
          state_d    = ST_ACQUIRE;
        end
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (step_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACQUIRE;
      good_cnt_q  <= '0;
      prev_bin_q  <= '0;
      err_cnt_q   <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      prev_bin_q  <= prev_bin_d;
      err_cnt_q   <= err_cnt_d;
      bin_valid_q <= s1_valid_q;
      step_err_q  <= step_err_d;
      if (s1_valid_q) begin
        bin_q <= s1_bin;
      end
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign step_err  = step_err_q;
  assign locked    = (state_q == ST_LOCKED);
  assign err_count = err_cnt_q;

`ifdef GRAY_MON_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (step_err_d) begin
      sticky_q <= 1'b1;
    end
  end

  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
module tb_gray_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_in;
  logic       in_valid;
  logic [7:0] bin_out;
  logic       bin_valid;
  logic       step_err;
  logic       locked;
  logic [7:0] err_count;
`ifdef GRAY_MON_STICKY_EN
  logic       err_sticky;
`endif

  gray_monitor #(.WIDTH(8), .ERR_CNT_W(8), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .in_valid   (in_valid),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_err   (step_err),
    .locked     (locked),
    .err_count  (err_count)
`ifdef GRAY_MON_STICKY_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic [7:0] bin;
    logic       err;
    logic       lk;
    logic [7:0] ec;
    logic       st;
  } exp_t;

  exp_t q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: 0 acquire, 1 track, 2 locked.
  int         m_state;
  logic [7:0] m_prev;
  int         m_good;
  int         m_ec;
  logic       m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] to_gray(input int b);
    logic [7:0] v;
    v = 8'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [7:0] from_gray(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_prev  = 8'd0;
    m_good  = 0;
    m_ec    = 0;
    m_st    = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [7:0] g);
    exp_t       e;
    logic [7:0] b;
    logic [7:0] d;
    @(posedge clk);
    #1;
    in_valid = v;
    gray_in  = g;
    if (v) begin
      b     = from_gray(g);
      e.err = 1'b0;
      if (m_state == 0) begin
        m_state = 1;
        m_good  = 0;
      end else begin
        d = b - m_prev;
        if (d == 8'd0 || d == 8'd1) begin
          if (m_state == 1) begin
            m_good++;
            if (m_good == 4) m_state = 2;
          end
        end else begin
          e.err   = 1'b1;
          m_good  = 0;
          m_state = 1;
        end
      end
      m_prev = b;
      if (e.err) begin
        if (m_ec < 255) m_ec++;
        m_st = 1'b1;
      end
      e.due = cyc + 2;
      e.bin = b;
      e.lk  = (m_state == 2);
      e.ec  = 8'(m_ec);
      e.st  = m_st;
      q.push_back(e);
    end
  endtask

  task automatic send_bins(input int first, input int last);
    for (int i = first; i <= last; i++) drive(1'b1, to_gray(i));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bin_valid === 1'b1) begin
      chk("spurious_bin_valid", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("latency_cycle", 32'(cyc), 32'(e.due));
        chk("bin_out", 32'(bin_out), 32'(e.bin));
        chk("step_err", 32'(step_err), 32'(e.err));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("err_count", 32'(err_count), 32'(e.ec));
`ifdef GRAY_MON_STICKY_EN
        chk("err_sticky", 32'(err_sticky), 32'(e.st));
`endif
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_bin_valid", 32'(bin_valid), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
`ifdef GRAY_MON_STICKY_EN
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Count 0..4 from reset: reference then four good steps reaches lock.
    send_bins(0, 4);
    idle(3);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_err_count", 32'(err_count), 32'd0);

    // Locked at 10, jump to 13, then relock on 14..17.
    send_bins(5, 10);
    drive(1'b1, to_gray(13));
    idle(3);
    chk("t3_unlocked", 32'(locked), 32'd0);
    chk("t3_err_count", 32'(err_count), 32'd1);
    send_bins(14, 17);
    idle(3);
    chk("t3_relocked", 32'(locked), 32'd1);

    // Wrap 255 (Gray 0x80) -> 0 is a +1 step.
    send_bins(251, 255);
    drive(1'b1, 8'h00);
    idle(3);
    chk("t2_wrap_locked", 32'(locked), 32'd1);
    chk("t2_err_count", 32'(err_count), 32'd2);

    // Same sample three times with two-cycle gaps.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, to_gray(0));
      idle(2);
    end
    idle(2);
    chk("t4_err_count", 32'(err_count), 32'd2);
    chk("t4_locked", 32'(locked), 32'd1);

    // Alternate 0 / 128 to force enough bad steps to saturate the counter.
    for (int i = 0; i < 301; i++) drive(1'b1, to_gray((i % 2 == 1) ? 128 : 0));
    idle(3);
    chk("t5_saturated", 32'(err_count), 32'd255);

    // Relock, then reset in the middle of a stream.
    send_bins(1, 6);
    drive(1'b1, to_gray(7));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    model_reset();
    in_valid = 1'b0;
    chk("t6_bin_out", 32'(bin_out), 32'd0);
    chk("t6_bin_valid", 32'(bin_valid), 32'd0);
    chk("t6_step_err", 32'(step_err), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_err_count", 32'(err_count), 32'd0);
`ifdef GRAY_MON_STICKY_EN
    chk("t6_err_sticky", 32'(err_sticky), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, to_gray(77));
    drive(1'b1, to_gray(78));
    drive(1'b1, to_gray(200));
    idle(4);
    chk("t6_post_err_count", 32'(err_count), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
